// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU sequencing controller: opcode values,
//   controller state encoding and instruction field positions.
//   Instruction word (9 bits): [8:6] op, [5:0] imm6
//     rd = imm6[5:4], rs = imm6[3:2], LDI value = imm6[2:0]
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_LDI  = 3'b011;
   localparam logic [2:0] OP_BZ   = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b101;

   localparam int unsigned INSN_W = 9;
   localparam int unsigned OP_HI  = 8;
   localparam int unsigned OP_LO  = 6;
   localparam int unsigned IMM_HI = 5;
   localparam int unsigned IMM_LO = 0;
   localparam int unsigned RD_HI  = 5;
   localparam int unsigned RD_LO  = 4;
   localparam int unsigned RS_HI  = 3;
   localparam int unsigned RS_LO  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // Ops 000..011 all go through the ALU and write R[rd] plus the zero flag.
   function automatic logic is_alu_class(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_regfile.sv
// alu_seq_regfile
//   4 x 8-bit register file, cleared by reset.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     i_we/i_waddr/i_wdata  synchronous write port
//     i_raddr_a/o_rdata_a   combinational read port A
//     i_raddr_b/o_rdata_b   combinational read port B
//     i_dbg_sel/o_dbg_data  combinational debug read port
module alu_seq_regfile (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_we,
   input  logic [1:0] i_waddr,
   input  logic [7:0] i_wdata,
   input  logic [1:0] i_raddr_a,
   output logic [7:0] o_rdata_a,
   input  logic [1:0] i_raddr_b,
   output logic [7:0] o_rdata_b,
   input  logic [1:0] i_dbg_sel,
   output logic [7:0] o_dbg_data
);

   logic [7:0] r_regs [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 4; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a  = r_regs[i_raddr_a];
   assign o_rdata_b  = r_regs[i_raddr_b];
   assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Fetch/decode/execute/write-back controller around an external 8-bit ALU.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     start                      pulse; (re)starts at PC 0 from IDLE or HALT
//     imem_req/addr/ack/rdata    instruction fetch handshake
//     alu_in1/in2/op/imm6/imm_mode  registered ALU operands (loaded in DECODE)
//     alu_out, alu_zero          ALU result and zero flag
//     busy, halted               status
//     dbg_sel, dbg_data          register-file debug read
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                imem_req,
   output logic [PC_W-1:0]     imem_addr,
   input  logic                imem_ack,
   input  logic [INSN_W-1:0]   imem_rdata,
   output logic [7:0]          alu_in1,
   output logic [7:0]          alu_in2,
   output logic [2:0]          alu_op,
   output logic [5:0]          alu_imm6,
   output logic                alu_imm_mode,
   input  logic [7:0]          alu_out,
   input  logic                alu_zero,
   output logic                busy,
   output logic                halted,
   input  logic [1:0]          dbg_sel,
   output logic [7:0]          dbg_data
);

   state_t              r_state, w_state_nxt;
   logic [PC_W-1:0]     r_pc, w_pc_nxt;
   logic [INSN_W-1:0]   r_ir;
   logic [7:0]          r_res;
   logic                r_zflag;
   logic [7:0]          r_alu_in1, r_alu_in2;
   logic [2:0]          r_alu_op;
   logic [5:0]          r_alu_imm6;
   logic                r_alu_imm_mode;

   logic                w_ir_ld, w_alu_ld, w_ex, w_we;
   logic [2:0]          w_op;
   logic [5:0]          w_imm6;
   logic [1:0]          w_rd, w_rs;
   logic [7:0]          w_rdata_rd, w_rdata_rs;
   logic [PC_W-1:0]     w_pc_inc, w_pc_br;

   assign w_op     = r_ir[OP_HI:OP_LO];
   assign w_imm6   = r_ir[IMM_HI:IMM_LO];
   assign w_rd     = r_ir[RD_HI:RD_LO];
   assign w_rs     = r_ir[RS_HI:RS_LO];
   assign w_pc_inc = r_pc + PC_W'(1);
   assign w_pc_br  = r_pc + PC_W'($signed(w_imm6));

   // ir still holds the instruction in WB, so rd comes straight from it.
   alu_seq_regfile u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (w_we),
      .i_waddr    (w_rd),
      .i_wdata    (r_res),
      .i_raddr_a  (w_rd),
      .o_rdata_a  (w_rdata_rd),
      .i_raddr_b  (w_rs),
      .o_rdata_b  (w_rdata_rs),
      .i_dbg_sel  (dbg_sel),
      .o_dbg_data (dbg_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_ld     = 1'b0;
      w_alu_ld    = 1'b0;
      w_ex        = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               w_pc_nxt    = '0;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               w_ir_ld     = 1'b1;
               w_state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_alu_class(w_op)) begin
               w_alu_ld    = 1'b1;
               w_state_nxt = ST_EXEC;
            end else if (w_op == OP_HALT) begin
               w_state_nxt = ST_HALT;
            end else begin
               w_pc_nxt    = ((w_op == OP_BZ) && r_zflag) ? w_pc_br : w_pc_inc;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_EXEC: begin
            w_ex        = 1'b1;
            w_state_nxt = ST_WB;
         end
         ST_WB: begin
            w_we        = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_FETCH;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc           <= '0;
         r_ir           <= '0;
         r_res          <= '0;
         r_zflag        <= 1'b0;
         r_alu_in1      <= '0;
         r_alu_in2      <= '0;
         r_alu_op       <= '0;
         r_alu_imm6     <= '0;
         r_alu_imm_mode <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_ir_ld) begin
            r_ir <= imem_rdata;
         end
         if (w_alu_ld) begin
            r_alu_in1      <= w_rdata_rd;
            r_alu_in2      <= w_rdata_rs;
            r_alu_op       <= w_op;
            r_alu_imm6     <= w_imm6;
            r_alu_imm_mode <= (w_op == OP_LDI);
         end
         if (w_ex) begin
            r_res   <= alu_out;
            r_zflag <= alu_zero;
         end
      end
   end

   // Decoded straight from state so reset drops the request asynchronously.
   assign imem_req     = (r_state == ST_FETCH);
   assign imem_addr    = r_pc;
   assign busy         = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                         (r_state == ST_EXEC)  || (r_state == ST_WB);
   assign halted       = (r_state == ST_HALT);
   assign alu_in1      = r_alu_in1;
   assign alu_in2      = r_alu_in2;
   assign alu_op       = r_alu_op;
   assign alu_imm6     = r_alu_imm6;
   assign alu_imm_mode = r_alu_imm_mode;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack;
   logic [8:0] imem_rdata;
   logic [7:0] alu_in1, alu_in2;
   logic [2:0] alu_op;
   logic [5:0] alu_imm6;
   logic       alu_imm_mode;
   logic [7:0] alu_out;
   logic       alu_zero;
   logic       busy, halted;
   logic [1:0] dbg_sel = 2'd0;
   logic [7:0] dbg_data;

   logic [8:0] mem [256];
   logic       auto_ack = 1'b1;
   logic       man_ack = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         f_addr[$];
   int         f_cyc[$];

   localparam logic [8:0] I_HALT = 9'b101_000000;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign imem_ack   = auto_ack ? imem_req : man_ack;
   assign imem_rdata = mem[imem_addr];

   // External ALU
   always_comb begin
      alu_out = 8'h00;
      if (alu_imm_mode) alu_out = {5'b0, alu_imm6[2:0]};
      else case (alu_op)
         3'b000: alu_out = alu_in1 + alu_in2;
         3'b001: alu_out = alu_in1 - alu_in2;
         3'b010: alu_out = alu_in1 & alu_in2;
         default: alu_out = 8'h00;
      endcase
      alu_zero = (alu_out == 8'h00);
   end

   always @(negedge clk) begin
      if (imem_req && imem_ack) begin
         f_addr.push_back(int'(imem_addr));
         f_cyc.push_back(cyc);
      end
   end

   alu_seq_ctrl #(.PC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
      .alu_imm6(alu_imm6), .alu_imm_mode(alu_imm_mode),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .busy(busy), .halted(halted),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) mem[i] = I_HALT;
      f_addr.delete();
      f_cyc.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (!halted && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, halted}, 32'd1);
   endtask

   task automatic wait_fetch(input int a, input string tag);
      int n = 0;
      while (!(imem_req && imem_ack && int'(imem_addr) == a) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, (imem_req && imem_ack)}, 32'd1);
   endtask

   task automatic chk_reg(input logic [1:0] sel, input logic [7:0] exp, input string tag);
      dbg_sel = sel;
      #1;
      chk(tag, {24'd0, dbg_data}, {24'd0, exp});
   endtask

   task automatic chk_all_zero(input string tag);
      dbg_sel = 2'd0;
      #1;
      chk({tag, "_req"},  {31'd0, imem_req}, 32'd0);
      chk({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
      chk({tag, "_in1"},  {24'd0, alu_in1}, 32'd0);
      chk({tag, "_in2"},  {24'd0, alu_in2}, 32'd0);
      chk({tag, "_op"},   {29'd0, alu_op}, 32'd0);
      chk({tag, "_imm"},  {26'd0, alu_imm6}, 32'd0);
      chk({tag, "_imode"},{31'd0, alu_imm_mode}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_halt"}, {31'd0, halted}, 32'd0);
      chk({tag, "_dbg"},  {24'd0, dbg_data}, 32'd0);
      chk({tag, "_state"}, {29'd0, dut.r_state}, {29'd0, ST_IDLE});
   endtask

   initial begin
      fill_halt();
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("post_rst");
      chk("post_rst_zf", {31'd0, dut.r_zflag}, 32'd0);

      // LDI R1,5; LDI R2,3; ADD R1,R2; HALT
      mem[0] = 9'b011_010101;
      mem[1] = 9'b011_100011;
      mem[2] = 9'b000_011000;
      mem[3] = I_HALT;
      pulse_start();
      wait_halt("t1_halt");
      chk_reg(2'd1, 8'd8, "t1_r1");
      chk_reg(2'd2, 8'd3, "t1_r2");
      chk("t1_zf", {31'd0, dut.r_zflag}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd0);
      chk("t1_nfetch", f_addr.size(), 32'd4);
      if (f_addr.size() == 4) begin
         chk("t1_cyc01", f_cyc[1] - f_cyc[0], 32'd4);
         chk("t1_cyc12", f_cyc[2] - f_cyc[1], 32'd4);
         chk("t1_cyc23", f_cyc[3] - f_cyc[2], 32'd4);
      end

      // BZ +2 at 3, zflag = 0 -> falls through to 4
      fill_halt();
      mem[0] = 9'b011_000100;
      mem[1] = 9'b011_110011;
      mem[2] = 9'b001_001100;
      mem[3] = 9'b100_000010;
      pulse_start();
      wait_halt("t2a_halt");
      chk("t2a_zf", {31'd0, dut.r_zflag}, 32'd0);
      chk_reg(2'd0, 8'd1, "t2a_r0");
      chk("t2a_nfetch", f_addr.size(), 32'd5);
      if (f_addr.size() == 5) chk("t2a_addr", f_addr[4], 32'd4);

      // Same with R3 = 4 -> SUB gives zero, branch taken to 5
      fill_halt();
      mem[0] = 9'b011_000100;
      mem[1] = 9'b011_110100;
      mem[2] = 9'b001_001100;
      mem[3] = 9'b100_000010;
      pulse_start();
      wait_halt("t2b_halt");
      chk("t2b_zf", {31'd0, dut.r_zflag}, 32'd1);
      chk_reg(2'd0, 8'd0, "t2b_r0");
      chk("t2b_nfetch", f_addr.size(), 32'd5);
      if (f_addr.size() == 5) begin
         chk("t2b_addr", f_addr[4], 32'd5);
         chk("t2b_bzcyc", f_cyc[4] - f_cyc[3], 32'd2);
      end

      // BZ -1 at 0 with zflag = 1 wraps to 255
      fill_halt();
      mem[0] = 9'b100_111111;
      pulse_start();
      wait_halt("t3_halt");
      chk("t3_nfetch", f_addr.size(), 32'd2);
      if (f_addr.size() == 2) chk("t3_addr", f_addr[1], 32'd255);
      chk("t3_pc", {24'd0, imem_addr}, 32'd255);

      // Ack delayed 3 cycles; memory word changes before the ack
      fill_halt();
      auto_ack = 1'b0;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         chk("t4_req", {31'd0, imem_req}, 32'd1);
         chk("t4_addr", {24'd0, imem_addr}, 32'd0);
         @(negedge clk);
      end
      chk("t4_req_ackcyc", {31'd0, imem_req}, 32'd1);
      mem[0] = 9'b011_100111;
      man_ack = 1'b1;
      @(negedge clk) man_ack = 1'b0;
      chk("t4_req_drop", {31'd0, imem_req}, 32'd0);
      chk("t4_ir", {23'd0, dut.r_ir}, {23'd0, 9'b011_100111});
      auto_ack = 1'b1;
      wait_halt("t4_halt");
      chk_reg(2'd2, 8'd7, "t4_r2");

      // Start pulses in FETCH and EXEC ignored; restart after HALT
      fill_halt();
      mem[0] = 9'b011_010001;
      mem[1] = 9'b011_100010;
      mem[2] = 9'b000_011000;
      pulse_start();
      wait_fetch(2, "t5_fetch2");
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk) start = 1'b1;
      chk("t5_exec", {29'd0, dut.r_state}, {29'd0, ST_EXEC});
      @(negedge clk) start = 1'b0;
      wait_halt("t5_halt");
      chk_reg(2'd1, 8'd3, "t5_r1");
      chk("t5_nfetch", f_addr.size(), 32'd4);
      if (f_addr.size() == 4) chk("t5_addr3", f_addr[3], 32'd3);
      f_addr.delete();
      f_cyc.delete();
      pulse_start();
      chk("t5_refetch", {31'd0, (imem_req && imem_addr == 8'd0)}, 32'd1);
      wait_halt("t5_halt2");

      // Reset during EXEC of ADD
      pulse_start();
      wait_fetch(2, "t6_fetch2");
      @(negedge clk);
      @(negedge clk);
      chk("t6_exec", {29'd0, dut.r_state}, {29'd0, ST_EXEC});
      #1 rst_n = 1'b0;
      chk_all_zero("t6_rst");
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_reg(2'd1, 8'd0, "t6_r1");
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_state", {29'd0, dut.r_state}, {29'd0, ST_IDLE});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
